request_conditioner: RTL and testbench
======================================

# request_conditioner

Front-end input stage of the traffic light controller. Synchronizes and debounces the raw `sensor` and `walk_request` pins, and latches walk requests until the top controller acknowledges them. Turns `reprogram` into a single-cycle pulse that carries a captured timing parameter. All outputs feed the top controller directly.

## Interface
- `SYNC_STAGES`, 2: flip-flop depth of each input synchronizer (≥2).
- `DEBOUNCE_CYCLES`, 4: consecutive stable cycles needed before a clean output changes (≥1).
- `clock`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state while low.
- `sensor`  in  1  raw side-road vehicle sensor.
- `walk_request`  in  1  raw pedestrian button.
- `walk_clear`  in  1  synchronous acknowledge from the controller; clears `walk_pending`.
- `reprogram`  in  1  raw reprogram strobe.
- `time_param_selector`  in  2  raw parameter index.
- `time_value`  in  4  raw parameter value.
- `sensor_clean`  out  1  debounced sensor level.
- `walk_pending`  out  1  latched walk request.
- `reprogram_pulse`  out  1  one-cycle reprogram strobe.
- `param_sel`  out  2  captured selector, valid while `reprogram_pulse`=1 and held afterwards.
- `param_value`  out  4  captured value, same validity.

## Operation
- The reset value of every output and internal register is 0. While `reset` is low, outputs stay 0 regardless of inputs.
- **Sync:** `sensor`, `walk_request` and `reprogram` each pass through a `SYNC_STAGES`-deep register chain.
- **Debounce** (sensor and walk, independently):
  - A counter of width clog2(`DEBOUNCE_CYCLES`)+1 increments on each edge where the synced bit differs from the clean bit.
  - The counter clears to 0 on any edge where they match.
  - On the edge where the counter would reach `DEBOUNCE_CYCLES`, the clean bit toggles and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` synced cycles never changes the clean output.
- **Walk latch** (two states, IDLE and PENDING):
  - IDLE→PENDING on the edge where clean walk goes 0→1.
  - PENDING→IDLE on an edge with `walk_clear`=1.
  - If the set event and `walk_clear` occur on the same edge, set wins and the state stays or becomes PENDING.
  - Holding the button held does not re-set after a clear; a new 0→1 clean transition is required.
  - `walk_clear` in IDLE has no effect.
- **Reprogram:**
  - A rising edge is detected on the synced `reprogram`.
  - On that edge, `time_param_selector` and `time_value` are registered into `param_sel`/`param_value`, and `reprogram_pulse`=1 for exactly one cycle.
  - Holding `reprogram` high produces no further pulses.
  - The selector and value buses must be stable from at least `SYNC_STAGES`+1 cycles before `reprogram` rises until the pulse.

## Timing
- Raw sensor/walk change to clean change: `SYNC_STAGES`+`DEBOUNCE_CYCLES` rising edges, which is 6 with defaults.
- `walk_pending` rises on the same edge as clean walk, so also 6 edges from raw.
- Raw `reprogram` rise to `reprogram_pulse` high: `SYNC_STAGES`+1 edges, which is 3 with defaults. The pulse is one cycle wide.
- `walk_clear` sampled at edge n drops `walk_pending` after edge n.
- **Reset mid-operation:** counters, sync chains, the latch and captured parameters all clear asynchronously. After release, a raw input already high needs the full 6 edges to appear.

## Configuration
- `REPROGRAM_CAPTURE_EN` defined: reprogram sync, edge detect and parameter capture are built as described.
- `REPROGRAM_CAPTURE_EN` undefined:
  - `reprogram_pulse`, `param_sel` and `param_value` are tied to 0.
  - `reprogram`, `time_param_selector` and `time_value` are unused.
  - The sensor and walk paths are unchanged.

## Structure
- Shared package `tlc_pkg`:
  - Default `SYNC_STAGES`/`DEBOUNCE_CYCLES` constants.
  - Parameter selector width (2) and value width (4).
  - Walk latch state typedef (IDLE, PENDING).
- Sub-module `sync_debounce` (one synchronizer plus debounce counter; ports `clock`, `reset`, `din`, `dout`), instantiated for sensor and walk.
- The reprogram path reuses the synchronizer only, inline, with no debounce.

## Test plan
- **Reset:** hold `reset`=0 with all inputs at 1 → all outputs 0. Release → `sensor_clean` and `walk_pending` = 1 exactly 6 edges later.
- **Glitch rejection:** `sensor` high for 3 cycles, then low → `sensor_clean` stays 0. `sensor` high for 10 cycles → `sensor_clean` rises at edge 6 and falls 6 edges after `sensor` drops.
- **Walk handshake:** press `walk_request` for 8 cycles → `walk_pending`=1 at edge 6. Pulse `walk_clear` → 0 next edge. No re-set while the button is still held.
- **Simultaneous:** clean walk rise coincides with `walk_clear`=1 → `walk_pending`=1.
- **Reprogram:** selector=0, value=4, then `reprogram` high for 1 cycle → one-cycle `reprogram_pulse` 3 edges later, with `param_sel`=0 and `param_value`=4 held afterwards. `reprogram` held high for 20 cycles → a single pulse.
- **Macro off:** `REPROGRAM_CAPTURE_EN` undefined, toggle `reprogram` → `reprogram_pulse`, `param_sel` and `param_value` remain 0.

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared constants and types for the traffic light controller front end.
// Holds default synchronizer/debounce depths, parameter bus widths and the walk latch states.
package tlc_pkg;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int PARAM_SEL_W         = 2;
  localparam int PARAM_VAL_W         = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } walk_state_t;

endpackage

// File: rtl/request_conditioner_if.sv
// Controller-facing bundle of the request conditioner.
// The master side is the conditioner; the slave side is the top controller.
interface request_conditioner_if;
  import tlc_pkg::*;

  logic                   sensor_clean;
  logic                   walk_pending;
  logic                   walk_clear;
  logic                   reprogram_pulse;
  logic [PARAM_SEL_W-1:0] param_sel;
  logic [PARAM_VAL_W-1:0] param_value;

  modport master (
    output sensor_clean, walk_pending, reprogram_pulse, param_sel, param_value,
    input  walk_clear
  );

  modport slave (
    input  sensor_clean, walk_pending, reprogram_pulse, param_sel, param_value,
    output walk_clear
  );

endinterface

// File: rtl/sync_debounce.sv
// One raw pin: SYNC_STAGES-deep synchronizer followed by a debounce counter.
// `rise` is high during the cycle whose closing edge takes dout from 0 to 1.
module sync_debounce
  import tlc_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [CW-1:0]          count_reg;
  logic                   clean_reg;
  logic                   synced;
  logic                   settle;

  assign synced = sync_reg[SYNC_STAGES-1];
  // Final disagreeing sample: the counter would reach DEBOUNCE_CYCLES on this edge.
  assign settle = (synced != clean_reg) && (count_reg == CW'(DEBOUNCE_CYCLES - 1));
  assign rise   = settle && !clean_reg;
  assign dout   = clean_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_reg  <= '0;
      count_reg <= '0;
      clean_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
      if (synced == clean_reg) begin
        count_reg <= '0;
      end else if (settle) begin
        count_reg <= '0;
        clean_reg <= ~clean_reg;
      end else begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/request_conditioner.sv
// Input stage of the traffic light controller: debounced sensor, latched walk request and
// a one-shot reprogram strobe with parameter capture (built only with REPROGRAM_CAPTURE_EN).
module request_conditioner
  import tlc_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   sensor,
  input  logic                   walk_request,
  input  logic                   reprogram,
  input  logic [PARAM_SEL_W-1:0] time_param_selector,
  input  logic [PARAM_VAL_W-1:0] time_value,
  request_conditioner_if.master  ctrl
);

  logic        sensor_clean;
  logic        unused_sensor_rise;
  logic        unused_walk_level;
  logic        walk_rise;
  walk_state_t walk_state_reg;
  logic        walk_pending_reg;

  sync_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sensor (
    .clock(clock),
    .reset(reset),
    .din  (sensor),
    .dout (sensor_clean),
    .rise (unused_sensor_rise)
  );

  sync_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_walk (
    .clock(clock),
    .reset(reset),
    .din  (walk_request),
    .dout (unused_walk_level),
    .rise (walk_rise)
  );

  // A fresh button press outranks a coincident acknowledge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      walk_state_reg   <= IDLE;
      walk_pending_reg <= 1'b0;
    end else begin
      case (walk_state_reg)
        IDLE: begin
          if (walk_rise) begin
            walk_state_reg   <= PENDING;
            walk_pending_reg <= 1'b1;
          end
        end
        PENDING: begin
          if (ctrl.walk_clear && !walk_rise) begin
            walk_state_reg   <= IDLE;
            walk_pending_reg <= 1'b0;
          end
        end
      endcase
    end
  end

  assign ctrl.sensor_clean = sensor_clean;
  assign ctrl.walk_pending = walk_pending_reg;

`ifdef REPROGRAM_CAPTURE_EN
  logic [SYNC_STAGES-1:0] reprog_sync_reg;
  logic                   reprog_prev_reg;
  logic                   reprog_pulse_reg;
  logic [PARAM_SEL_W-1:0] param_sel_reg;
  logic [PARAM_VAL_W-1:0] param_value_reg;
  logic                   reprog_rise;

  assign reprog_rise = reprog_sync_reg[SYNC_STAGES-1] && !reprog_prev_reg;

  // Selector/value are sampled raw; the source keeps them steady around the strobe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      reprog_sync_reg  <= '0;
      reprog_prev_reg  <= 1'b0;
      reprog_pulse_reg <= 1'b0;
      param_sel_reg    <= '0;
      param_value_reg  <= '0;
    end else begin
      reprog_sync_reg  <= {reprog_sync_reg[SYNC_STAGES-2:0], reprogram};
      reprog_prev_reg  <= reprog_sync_reg[SYNC_STAGES-1];
      reprog_pulse_reg <= reprog_rise;
      if (reprog_rise) begin
        param_sel_reg   <= time_param_selector;
        param_value_reg <= time_value;
      end
    end
  end

  assign ctrl.reprogram_pulse = reprog_pulse_reg;
  assign ctrl.param_sel       = param_sel_reg;
  assign ctrl.param_value     = param_value_reg;
`else
  logic unused_reprogram;
  assign unused_reprogram     = ^{reprogram, time_param_selector, time_value};
  assign ctrl.reprogram_pulse = 1'b0;
  assign ctrl.param_sel       = '0;
  assign ctrl.param_value     = '0;
`endif

endmodule

// File: tb/tb_request_conditioner.sv
// Bench for request_conditioner: directed scenarios plus random traffic against a
// history-window reference model; reprogram expectations follow REPROGRAM_CAPTURE_EN.
module tb_request_conditioner;
  import tlc_pkg::*;

  localparam int S = SYNC_STAGES_DEF;
  localparam int D = DEBOUNCE_CYCLES_DEF;
`ifdef REPROGRAM_CAPTURE_EN
  localparam bit CAP_EN = 1'b1;
`else
  localparam bit CAP_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       sensor = 1'b0;
  logic       walk_request = 1'b0;
  logic       reprogram = 1'b0;
  logic [1:0] time_param_selector = '0;
  logic [3:0] time_value = '0;

  int n_compared = 0;
  int n_mismatch = 0;

  request_conditioner_if ctrl ();

  request_conditioner #(
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .sensor             (sensor),
    .walk_request       (walk_request),
    .reprogram          (reprogram),
    .time_param_selector(time_param_selector),
    .time_value         (time_value),
    .ctrl               (ctrl)
  );

  always #5 clock = ~clock;

  // Reference model: raw sample histories per edge. A pin's synced value is its raw
  // sample S edges earlier; a clean level flips once the last D synced samples all
  // disagree with it.
  bit [31:0] sens_raw, walk_raw, rep_raw, sens_syn, walk_syn;
  bit        m_sensor, m_walk, m_pending, m_pulse;
  bit [1:0]  m_sel;
  bit [3:0]  m_val;

  always @(posedge clock or negedge reset) begin : model
    bit walk_rose;
    if (!reset) begin
      sens_raw = '0; walk_raw = '0; rep_raw = '0; sens_syn = '0; walk_syn = '0;
      m_sensor = 0; m_walk = 0; m_pending = 0; m_pulse = 0; m_sel = '0; m_val = '0;
    end else begin
      sens_raw = {sens_raw[30:0], sensor};
      walk_raw = {walk_raw[30:0], walk_request};
      rep_raw  = {rep_raw[30:0], reprogram};
      sens_syn = {sens_syn[30:0], sens_raw[S]};
      walk_syn = {walk_syn[30:0], walk_raw[S]};
      if (sens_syn[D-1:0] == {D{~m_sensor}}) m_sensor = ~m_sensor;
      walk_rose = (walk_syn[D-1:0] == {D{~m_walk}}) && !m_walk;
      if (walk_syn[D-1:0] == {D{~m_walk}}) m_walk = ~m_walk;
      if (walk_rose) m_pending = 1'b1;
      else if (ctrl.walk_clear) m_pending = 1'b0;
      m_pulse = CAP_EN && rep_raw[S] && !rep_raw[S+1];
      if (m_pulse) begin
        m_sel = time_param_selector;
        m_val = time_value;
      end
    end
  end

  task automatic idle(input int n);
    sensor = 0; walk_request = 0; reprogram = 0; ctrl.walk_clear = 1'b1;
    @(negedge clock);
    ctrl.walk_clear = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset();
    logic [8:0] obs;
    sensor = 1; walk_request = 1; reprogram = 1; ctrl.walk_clear = 0;
    time_param_selector = 2'd3; time_value = 4'd15;
    repeat (4) @(negedge clock);
    obs = {ctrl.sensor_clean, ctrl.walk_pending, ctrl.reprogram_pulse, ctrl.param_sel, ctrl.param_value};
    n_compared++;
    if (obs !== 9'b0) begin
      n_mismatch++;
      $display("FAIL reset_hold: outputs=%b required=%b", obs, 9'b0);
    end
    reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      n_compared++;
      if (ctrl.sensor_clean !== (k >= 6) || ctrl.walk_pending !== (k >= 6)) begin
        n_mismatch++;
        $display("FAIL reset_release edge %0d: clean=%b pending=%b required=%b", k,
                 ctrl.sensor_clean, ctrl.walk_pending, (k >= 6));
      end
      obs = {ctrl.sensor_clean, ctrl.walk_pending, ctrl.reprogram_pulse, ctrl.param_sel, ctrl.param_value};
      n_compared++;
      if (obs !== {m_sensor, m_pending, m_pulse, m_sel, m_val}) begin
        n_mismatch++;
        $display("FAIL reset_model edge %0d: outputs=%b required=%b", k, obs,
                 {m_sensor, m_pending, m_pulse, m_sel, m_val});
      end
    end
  endtask

  task automatic test_glitch();
    idle(12);
    sensor = 1;
    repeat (3) @(negedge clock);
    sensor = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      n_compared++;
      if (ctrl.sensor_clean !== 1'b0) begin
        n_mismatch++;
        $display("FAIL glitch_short cycle %0d: sensor_clean=%b required 0", k, ctrl.sensor_clean);
      end
    end
    sensor = 1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      n_compared++;
      if (ctrl.sensor_clean !== (k >= 6)) begin
        n_mismatch++;
        $display("FAIL sensor_rise edge %0d: sensor_clean=%b required %b", k, ctrl.sensor_clean, (k >= 6));
      end
    end
    sensor = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      n_compared++;
      if (ctrl.sensor_clean !== (k < 6)) begin
        n_mismatch++;
        $display("FAIL sensor_fall edge %0d: sensor_clean=%b required %b", k, ctrl.sensor_clean, (k < 6));
      end
    end
  endtask

  task automatic test_walk_handshake();
    idle(12);
    walk_request = 1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clock);
      n_compared++;
      if (ctrl.walk_pending !== (k == 6)) begin
        n_mismatch++;
        $display("FAIL walk_handshake edge %0d: walk_pending=%b required %b", k, ctrl.walk_pending, (k == 6));
      end
      ctrl.walk_clear = (k == 6);
    end
    walk_request = 0;
  endtask

  task automatic test_simultaneous();
    idle(12);
    walk_request = 1;
    repeat (6) @(negedge clock);
    walk_request = 0;
    repeat (10) @(negedge clock);
    n_compared++;
    if (ctrl.walk_pending !== 1'b1) begin
      n_mismatch++;
      $display("FAIL walk_held_after_release: walk_pending=%b required 1", ctrl.walk_pending);
    end
    walk_request = 1;
    repeat (5) @(negedge clock);
    ctrl.walk_clear = 1;
    @(negedge clock);
    ctrl.walk_clear = 0;
    n_compared++;
    if (ctrl.walk_pending !== 1'b1) begin
      n_mismatch++;
      $display("FAIL walk_set_wins: walk_pending=%b required 1", ctrl.walk_pending);
    end
    ctrl.walk_clear = 1;
    @(negedge clock);
    ctrl.walk_clear = 0;
    n_compared++;
    if (ctrl.walk_pending !== 1'b0) begin
      n_mismatch++;
      $display("FAIL walk_clear_after: walk_pending=%b required 0", ctrl.walk_pending);
    end
    walk_request = 0;
  endtask

  task automatic test_reprogram();
    int         pulses;
    logic [3:0] exp_val;
    idle(12);
    time_param_selector = 2'd0; time_value = 4'd4;
    repeat (S + 1) @(negedge clock);
    reprogram = 1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (k == 1) reprogram = 0;
      n_compared++;
      if (ctrl.reprogram_pulse !== (CAP_EN && k == 3)) begin
        n_mismatch++;
        $display("FAIL reprog_pulse edge %0d: pulse=%b required %b", k, ctrl.reprogram_pulse, (CAP_EN && k == 3));
      end
      exp_val = CAP_EN ? 4'd4 : 4'd0;
      if (k >= 3) begin
        n_compared++;
        if (ctrl.param_sel !== 2'd0 || ctrl.param_value !== exp_val) begin
          n_mismatch++;
          $display("FAIL reprog_capture edge %0d: sel=%0d value=%0d required sel=0 value=%0d", k,
                   ctrl.param_sel, ctrl.param_value, exp_val);
        end
      end
    end
    time_param_selector = 2'd2; time_value = 4'd9;
    repeat (5) @(negedge clock);
    n_compared++;
    if (ctrl.param_sel !== 2'd0 || ctrl.param_value !== exp_val) begin
      n_mismatch++;
      $display("FAIL reprog_hold: sel=%0d value=%0d required sel=0 value=%0d", ctrl.param_sel, ctrl.param_value, exp_val);
    end
    pulses = 0;
    reprogram = 1;
    for (int k = 1; k <= 26; k++) begin
      @(negedge clock);
      if (k == 20) reprogram = 0;
      if (ctrl.reprogram_pulse === 1'b1) pulses++;
    end
    n_compared++;
    if (pulses != (CAP_EN ? 1 : 0)) begin
      n_mismatch++;
      $display("FAIL reprog_held_single: pulses=%0d required %0d", pulses, (CAP_EN ? 1 : 0));
    end
    n_compared++;
    if (ctrl.param_sel !== (CAP_EN ? 2'd2 : 2'd0) || ctrl.param_value !== (CAP_EN ? 4'd9 : 4'd0)) begin
      n_mismatch++;
      $display("FAIL reprog_recapture: sel=%0d value=%0d required sel=%0d value=%0d", ctrl.param_sel,
               ctrl.param_value, (CAP_EN ? 2 : 0), (CAP_EN ? 9 : 0));
    end
  endtask

  task automatic test_random();
    logic [8:0] obs, exp;
    idle(12);
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(5) == 0) sensor = ~sensor;
      if ($urandom_range(6) == 0) walk_request = ~walk_request;
      if ($urandom_range(4) == 0) reprogram = ~reprogram;
      ctrl.walk_clear = ($urandom_range(7) == 0);
      time_param_selector = 2'($urandom);
      time_value = 4'($urandom);
      @(negedge clock);
      obs = {ctrl.sensor_clean, ctrl.walk_pending, ctrl.reprogram_pulse, ctrl.param_sel, ctrl.param_value};
      exp = {m_sensor, m_pending, m_pulse, m_sel, m_val};
      n_compared++;
      if (obs !== exp) begin
        n_mismatch++;
        $display("FAIL random cycle %0d: outputs=%b required=%b", c, obs, exp);
      end
    end
  endtask

  task automatic test_reset_midway();
    logic [8:0] obs;
    idle(4);
    sensor = 1; walk_request = 1;
    repeat (10) @(negedge clock);
    #2 reset = 1'b0;
    #1 obs = {ctrl.sensor_clean, ctrl.walk_pending, ctrl.reprogram_pulse, ctrl.param_sel, ctrl.param_value};
    n_compared++;
    if (obs !== 9'b0) begin
      n_mismatch++;
      $display("FAIL reset_async: outputs=%b required=%b", obs, 9'b0);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clock);
      n_compared++;
      if (ctrl.sensor_clean !== (k >= 6) || ctrl.walk_pending !== (k >= 6)) begin
        n_mismatch++;
        $display("FAIL reset_midway edge %0d: clean=%b pending=%b required=%b", k,
                 ctrl.sensor_clean, ctrl.walk_pending, (k >= 6));
      end
    end
  endtask

  initial begin
    ctrl.walk_clear = 1'b0;
    test_reset();
    test_glitch();
    test_walk_handshake();
    test_simultaneous();
    test_reprogram();
    test_random();
    test_reset_midway();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
